// File: rtl/pcm_player_if.sv
// pcm_player_if: sample ROM read bus between the player and the ROM
interface pcm_player_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] rom_addr;
  logic              rom_rd;
  logic [DATA_W-1:0] rom_data;
  modport master (output rom_addr, rom_rd, input rom_data);
  modport slave  (input rom_addr, rom_rd, output rom_data);
endinterface

// File: rtl/pcm_player.sv
// pcm_player: windowed PCM sample player with volume scaling and PWM output
module pcm_player #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 8,
  parameter int SAMPLE_DIV = 1024,
  parameter int ROM_LAT    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_en,
  input  logic              i_start,
  input  logic              i_stop,
  input  logic              i_loop,
  input  logic [ADDR_W-1:0] i_start_addr,
  input  logic [ADDR_W-1:0] i_end_addr,
  input  logic [3:0]        i_volume,
  pcm_player_if.master      rom,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_pwm
);
  localparam int TW = $clog2(SAMPLE_DIV);
  localparam int PW = DATA_W + 5;
  localparam logic [DATA_W-1:0] MID = {1'b1, {(DATA_W-1){1'b0}}};
  typedef enum logic {IDLE, PLAY} state_t;
  state_t            r_state;
  logic              r_busy, r_done, r_rd, r_last, r_fetched;
  logic [ADDR_W-1:0] r_rom_addr, r_addr, r_start, r_end;
  logic [DATA_W-1:0] r_nxt, r_level, r_pwm_cnt;
  logic [TW-1:0]     r_tick;
  logic              w_wrap;
  logic signed [PW-1:0] w_d, w_g, w_p, w_sh;
  logic [DATA_W-1:0] w_level;
  assign w_wrap  = r_tick == TW'(SAMPLE_DIV - 1);
  assign w_d     = $signed({5'b0, r_nxt} - {5'b0, MID});
  assign w_g     = $signed({{(DATA_W+1){1'b0}}, i_volume} + PW'(1));
  assign w_p     = w_d * w_g;
  assign w_sh    = w_p >>> 4;
  assign w_level = DATA_W'(w_sh) + MID;
  assign rom.rom_addr = r_rom_addr;
  assign rom.rom_rd   = r_rd;
  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_pwm  = r_busy & (r_pwm_cnt < r_level);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_pwm_cnt <= '0;
    else        r_pwm_cnt <= r_pwm_cnt + 1'b1;
  // rom_rd/rom_addr are loaded one cycle early so the strobe lands on tick 0
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state    <= IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_rd       <= 1'b0;
      r_rom_addr <= '0;
      r_addr     <= '0;
      r_start    <= '0;
      r_end      <= '0;
      r_last     <= 1'b0;
      r_fetched  <= 1'b0;
      r_nxt      <= '0;
      r_level    <= MID;
      r_tick     <= '0;
    end else begin
      r_done <= 1'b0;
      r_rd   <= 1'b0;
      if (r_state == IDLE) begin
        if (i_start && i_en && !i_stop) begin
          r_state    <= PLAY;
          r_busy     <= 1'b1;
          r_tick     <= '0;
          r_rd       <= 1'b1;
          r_rom_addr <= i_start_addr;
          r_addr     <= i_start_addr;
          r_start    <= i_start_addr;
          r_end      <= i_end_addr;
          r_last     <= 1'b0;
          r_fetched  <= 1'b0;
          r_level    <= MID;
        end
      end else if (i_stop || !i_en) begin
        r_state   <= IDLE;
        r_busy    <= 1'b0;
        r_fetched <= 1'b0;
        r_level   <= MID;
      end else begin
        r_tick <= w_wrap ? '0 : r_tick + 1'b1;
        if (r_tick == '0 && !r_last) begin
          r_fetched <= 1'b1;
          if (r_addr != r_end) r_addr <= r_addr + 1'b1;
          else if (i_loop)     r_addr <= r_start;
          else                 r_last <= 1'b1;
        end
        if (r_fetched && r_tick == TW'(ROM_LAT)) r_nxt <= rom.rom_data;
        if (w_wrap) begin
          if (r_fetched) begin
            r_level    <= w_level;
            r_fetched  <= 1'b0;
            r_rd       <= !r_last;
            r_rom_addr <= r_addr;
          end else begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_level <= MID;
            r_state <= IDLE;
          end
        end
      end
    end
endmodule

// File: tb/tb_pcm_player.sv
// tb_pcm_player: scoreboard bench for pcm_player (ROM returns addr[7:0])
module tb_pcm_player;
  logic clk = 0, rst_n = 0, en = 0, start = 0, stop = 0, loop = 0;
  logic [15:0] sa = 0, ea = 0;
  logic [3:0] vol = 15;
  logic busy, done, pwm;
  logic busy_d = 0;
  int n_chk = 0, n_err = 0, cyc = 0, busy_len = 0, done_cnt = 0, rd_cnt = 0, a;
  int exp_a[$], exp_l[$];
  pcm_player_if #(.ADDR_W(16), .DATA_W(8)) rom ();
  pcm_player #(.ADDR_W(16), .DATA_W(8), .SAMPLE_DIV(16), .ROM_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .i_en(en), .i_start(start), .i_stop(stop), .i_loop(loop),
    .i_start_addr(sa), .i_end_addr(ea), .i_volume(vol), .rom(rom),
    .o_busy(busy), .o_done(done), .o_pwm(pwm)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (rom.rom_rd) rom.rom_data <= rom.rom_addr[7:0];
  function automatic int scale(input int x, input int v);
    int p;
    p = (x - 128) * (v + 1);
    return 128 + (p >>> 4);
  endfunction
  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask
  task automatic step(input int n = 1);
    repeat (n) begin @(negedge clk); #1; end
  endtask
  task automatic play(input logic [15:0] s, input logic [15:0] e, input logic lp);
    sa = s; ea = e; loop = lp; start = 1;
    step();
    start = 0;
  endtask
  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 3000) begin step(); n++; end
    chk(tag, busy, 0);
  endtask
  task automatic flush();
    exp_a.delete();
    exp_l.delete();
  endtask
  // level updates land on period boundaries, right before the next fetch strobe
  always @(negedge clk) begin
    cyc = (busy && !busy_d) ? 0 : cyc + 1;
    if (!busy && busy_d) busy_len = cyc;
    busy_d = busy;
    if (done) done_cnt++;
    if (busy && cyc > 0 && cyc % 16 == 0) begin
      if (exp_l.size() == 0) chk("lvl_extra", exp_l.size(), 1);
      else chk("level", dut.r_level, exp_l.pop_front());
    end
    if (rom.rom_rd) begin
      rd_cnt++;
      chk("rd_spacing", cyc % 16, 0);
      if (exp_a.size() == 0) chk("rd_extra", exp_a.size(), 1);
      else begin
        a = exp_a.pop_front();
        chk("rd_addr", rom.rom_addr, a);
        exp_l.push_back(scale(a & 255, vol));
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    int d0, n, cnt;
    int va[3] = '{7, 0, 0};
    int xa[3] = '{'hC0, 'hC0, 0};
    step(2);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd", rom.rom_rd, 0);
    chk("rst_addr", rom.rom_addr, 0);
    chk("rst_pwm", pwm, 0);
    rst_n = 1; en = 1;
    step(2);
    d0 = done_cnt;
    exp_a = '{'h10, 'h11, 'h12, 'h13};
    play('h10, 'h13, 0);
    step(20);
    sa = 'h80; ea = 'h90; start = 1;
    step();
    start = 0;
    wait_idle("os_idle");
    step();
    chk("os_len", busy_len, 80);
    chk("os_done", done_cnt - d0, 1);
    chk("os_qa", exp_a.size(), 0);
    chk("os_ql", exp_l.size(), 0);
    d0 = done_cnt; rd_cnt = 0;
    exp_a = '{'hFFFE, 'hFFFF, 0, 1, 'hFFFE, 'hFFFF, 0, 1};
    play('hFFFE, 'h0001, 1);
    n = 0;
    while (rd_cnt < 5 && n < 500) begin step(); n++; end
    chk("lp_5th", rd_cnt, 5);
    loop = 0;
    wait_idle("lp_idle");
    step();
    chk("lp_len", busy_len, 144);
    chk("lp_done", done_cnt - d0, 1);
    chk("lp_qa", exp_a.size(), 0);
    for (int i = 0; i < 3; i++) begin
      vol = va[i];
      exp_a = '{xa[i]};
      play(16'(xa[i]), 16'(xa[i]), 0);
      wait_idle("vol_idle");
      step();
      chk("vol_ql", exp_l.size(), 0);
      chk("vol_len", busy_len, 32);
    end
    vol = 15;
    for (int i = 0; i < 30; i++) exp_a.push_back('h40);
    d0 = done_cnt;
    play('h40, 'h40, 1);
    step(40);
    cnt = 0;
    for (int i = 0; i < 256; i++) begin cnt += int'(pwm); step(); end
    chk("duty40", cnt, 64);
    stop = 1;
    step();
    stop = 0;
    chk("stop_busy", busy, 0);
    chk("stop_pwm", pwm, 0);
    flush();
    cnt = 0;
    for (int i = 0; i < 256; i++) begin cnt += int'(pwm); step(); end
    chk("idle_pwm", cnt, 0);
    chk("stop_done", done_cnt - d0, 0);
    d0 = done_cnt; rd_cnt = 0;
    exp_a = '{'h20, 'h21, 'h22, 'h23, 'h24};
    play('h20, 'h27, 0);
    n = 0;
    while (cyc != 37 && n < 200) begin step(); n++; end
    chk("stp_at", cyc, 37);
    stop = 1;
    step();
    stop = 0;
    chk("stp_busy", busy, 0);
    chk("stp_len", busy_len, 38);
    step(20);
    chk("stp_done", done_cnt - d0, 0);
    chk("stp_rds", rd_cnt, 3);
    flush();
    rd_cnt = 0;
    sa = 'h10; ea = 'h10; start = 1; stop = 1;
    step();
    start = 0; stop = 0;
    step(2);
    chk("ss_busy", busy, 0);
    chk("ss_rds", rd_cnt, 0);
    en = 0; start = 1;
    step();
    start = 0;
    step();
    chk("en0_start", busy, 0);
    en = 1;
    d0 = done_cnt;
    exp_a = '{'h30, 'h31};
    play('h30, 'h33, 0);
    step(20);
    en = 0;
    step();
    chk("en_busy", busy, 0);
    chk("en_pwm", pwm, 0);
    en = 1;
    step(20);
    chk("en_done", done_cnt - d0, 0);
    flush();
    exp_a = '{'h50, 'h51};
    play('h50, 'h53, 0);
    step(20);
    chk("pre_busy", busy, 1);
    #2 rst_n = 0;
    #1;
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    chk("mrst_rd", rom.rom_rd, 0);
    chk("mrst_addr", rom.rom_addr, 0);
    chk("mrst_pwm", pwm, 0);
    flush();
    step(2);
    rst_n = 1;
    step(2);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
